// File: rtl/bcd_arbiter.sv
// Two-requester round-robin front end for a shared binary-to-BCD converter.
// Grants one requester, runs the converter with a WAIT timeout, and stores each result per requester.
module bcd_arbiter #(
    parameter int unsigned INPUT_WIDTH    = 6,
    parameter int unsigned DECIMAL_DIGITS = 2,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic                        i_Req_A,
    input  logic                        i_Req_B,
    input  logic [INPUT_WIDTH-1:0]      i_Bin_A,
    input  logic [INPUT_WIDTH-1:0]      i_Bin_B,
    output logic                        o_Ack_A,
    output logic                        o_Ack_B,
    output logic [DECIMAL_DIGITS*4-1:0] o_BCD_A,
    output logic [DECIMAL_DIGITS*4-1:0] o_BCD_B,
    output logic                        o_Conv_Start,
    output logic [INPUT_WIDTH-1:0]      o_Conv_Binary,
    input  logic [DECIMAL_DIGITS*4-1:0] i_Conv_BCD,
    input  logic                        i_Conv_DV,
    output logic                        o_Busy,
    output logic                        o_Timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic              pointer;   // 0: A preferred on contention, 1: B preferred
    logic              grant_b;   // requester currently being served
    logic [CNT_W-1:0]  count;
    logic              pick_b_c;

    // A lone request always wins; the pointer only breaks ties.
    always_comb begin
        pick_b_c = i_Req_B && (!i_Req_A || pointer);
    end

    assign o_Busy = (state != S_IDLE);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= S_IDLE;
            pointer       <= 1'b0;
            grant_b       <= 1'b0;
            count         <= '0;
            o_Conv_Start  <= 1'b0;
            o_Ack_A       <= 1'b0;
            o_Ack_B       <= 1'b0;
            o_Timeout     <= 1'b0;
            o_Conv_Binary <= '0;
            o_BCD_A       <= '0;
            o_BCD_B       <= '0;
        end else begin
            o_Conv_Start <= 1'b0;
            o_Ack_A      <= 1'b0;
            o_Ack_B      <= 1'b0;
            o_Timeout    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_Req_A || i_Req_B) begin
                        grant_b       <= pick_b_c;
                        o_Conv_Binary <= pick_b_c ? i_Bin_B : i_Bin_A;
                        o_Conv_Start  <= 1'b1;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    count <= '0;
                    state <= S_WAIT;
                end
                // Valid data takes priority over the terminal count.
                S_WAIT: begin
                    if (i_Conv_DV) begin
                        if (grant_b) begin
                            o_BCD_B <= i_Conv_BCD;
                        end else begin
                            o_BCD_A <= i_Conv_BCD;
                        end
                        o_Ack_A <= !grant_b;
                        o_Ack_B <= grant_b;
                        state   <= S_DONE;
                    end else if (count == CNT_LAST) begin
                        o_Timeout <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    pointer <= ~grant_b;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_arbiter.sv
// Directed bench for bcd_arbiter with a behavioural converter stub of programmable latency.
module tb_bcd_arbiter;

    localparam int unsigned IW = 6;
    localparam int unsigned BW = 8;

    localparam int SEL_START = 0;
    localparam int SEL_ACK_A = 1;
    localparam int SEL_ACK_B = 2;
    localparam int SEL_TO    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_a, req_b;
    logic [IW-1:0] bin_a, bin_b;
    logic          ack_a, ack_b, conv_start, busy, tmo;
    logic [BW-1:0] bcd_a, bcd_b;
    logic [IW-1:0] conv_bin;
    logic [BW-1:0] stub_bcd;
    logic          stub_dv, stray_dv, conv_dv;

    logic          stub_en;
    int            stub_lat;

    int n_cmp = 0;
    int n_err = 0;
    int n_ack_a = 0;
    int n_ack_b = 0;
    int n_to = 0;
    int n_excl = 0;

    assign conv_dv = stub_dv | stray_dv;

    always #5 clk = ~clk;

    bcd_arbiter #(
        .INPUT_WIDTH   (IW),
        .DECIMAL_DIGITS(2),
        .TIMEOUT       (8)
    ) dut (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .i_Req_A      (req_a),
        .i_Req_B      (req_b),
        .i_Bin_A      (bin_a),
        .i_Bin_B      (bin_b),
        .o_Ack_A      (ack_a),
        .o_Ack_B      (ack_b),
        .o_BCD_A      (bcd_a),
        .o_BCD_B      (bcd_b),
        .o_Conv_Start (conv_start),
        .o_Conv_Binary(conv_bin),
        .i_Conv_BCD   (stub_bcd),
        .i_Conv_DV    (conv_dv),
        .o_Busy       (busy),
        .o_Timeout    (tmo)
    );

    function automatic logic [BW-1:0] to_bcd(input logic [IW-1:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    // Converter stub: answers each start pulse after stub_lat cycles.
    initial begin
        logic [IW-1:0] op;
        stub_dv  = 1'b0;
        stub_bcd = '0;
        forever begin
            @(negedge clk);
            if (conv_start && stub_en) begin
                op = conv_bin;
                repeat (stub_lat) @(negedge clk);
                stub_bcd = to_bcd(op);
                stub_dv  = 1'b1;
                @(negedge clk);
                stub_dv  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (ack_a) n_ack_a++;
        if (ack_b) n_ack_b++;
        if (tmo) n_to++;
        if (int'(ack_a) + int'(ack_b) + int'(tmo) > 1) n_excl++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_START: return conv_start;
            SEL_ACK_A: return ack_a;
            SEL_ACK_B: return ack_b;
            default:   return tmo;
        endcase
    endfunction

    // Steps until the selected output is high; n is the number of steps taken.
    task automatic wait_until(input int sel, input int max_cyc, input string tag, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            step();
            n++;
            if (sig(sel)) found = 1'b1;
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_any_ack(input int max_cyc, input string tag, output int who);
        logic found;
        found = 1'b0;
        who = -1;
        for (int i = 0; i < max_cyc && !found; i++) begin
            step();
            if (ack_a) begin who = 0; found = 1'b1; end
            else if (ack_b) begin who = 1; found = 1'b1; end
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        int n;
        int who;
        int acks0;
        int to0;
        int order[4];
        int exp_order[4] = '{0, 1, 0, 1};

        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; bin_a = '0; bin_b = '0;
        stub_en = 1'b1; stub_lat = 2; stray_dv = 1'b0;
        step(); step();
        check("rst_flags", 32'({conv_start, ack_a, ack_b, tmo, busy}), 32'd0);
        check("rst_bin", 32'(conv_bin), 32'd0);
        check("rst_bcd_a", 32'(bcd_a), 32'd0);
        check("rst_bcd_b", 32'(bcd_b), 32'd0);

        // Single request from A
        rst_n = 1'b1; req_a = 1'b1; bin_a = 6'd42;
        wait_until(SEL_START, 5, "t1_start", n);
        check("t1_conv_bin", 32'(conv_bin), 32'd42);
        check("t1_busy", 32'(busy), 32'd1);
        wait_until(SEL_ACK_A, 12, "t1_ack", n);
        check("t1_latency", 32'(n), 32'd3);
        check("t1_bcd_a", 32'(bcd_a), 32'h42);
        check("t1_bcd_b", 32'(bcd_b), 32'h00);
        req_a = 1'b0;
        step();
        check("t1_ack_pulse", 32'(ack_a), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_ack_count", 32'(n_ack_a), 32'd1);

        // Contention from reset: A first, then B after one IDLE cycle
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; req_a = 1'b1; bin_a = 6'd7; req_b = 1'b1; bin_b = 6'd63;
        step();
        check("t2_first_edge", 32'(conv_start), 32'd1);
        check("t2_bin_a", 32'(conv_bin), 32'd7);
        wait_until(SEL_ACK_A, 12, "t2_ack_a", n);
        check("t2_bcd_a", 32'(bcd_a), 32'h07);
        req_a = 1'b0;
        wait_until(SEL_START, 5, "t2_start_b", n);
        check("t2_gap", 32'(n), 32'd2);
        check("t2_bin_b", 32'(conv_bin), 32'd63);
        wait_until(SEL_ACK_B, 12, "t2_ack_b", n);
        check("t2_bcd_b", 32'(bcd_b), 32'h63);
        req_b = 1'b0;
        step();

        // Fairness with both requests held
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; req_a = 1'b1; bin_a = 6'd5; req_b = 1'b1; bin_b = 6'd19;
        for (int i = 0; i < 4; i++) begin
            wait_any_ack(15, "t3_ack", who);
            order[i] = who;
        end
        req_a = 1'b0; req_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        end
        check("t3_bcd_a", 32'(bcd_a), 32'h05);
        check("t3_bcd_b", 32'(bcd_b), 32'h19);
        step();

        // Timeout: the stub stays silent; 8 WAIT cycles then the pulse
        stub_en = 1'b0; req_a = 1'b1; bin_a = 6'd33;
        acks0 = n_ack_a + n_ack_b;
        wait_until(SEL_START, 5, "t4_start", n);
        wait_until(SEL_TO, 20, "t4_to", n);
        check("t4_to_delay", 32'(n), 32'd9);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_bcd_a", 32'(bcd_a), 32'h05);
        step();
        check("t4_restart", 32'(conv_start), 32'd1);
        req_a = 1'b0;
        wait_until(SEL_TO, 20, "t4_to2", n);
        check("t4_to2_delay", 32'(n), 32'd9);
        step();
        check("t4_to_pulse", 32'(tmo), 32'd0);
        check("t4_no_ack", 32'(n_ack_a + n_ack_b), 32'(acks0));
        check("t4_to_count", 32'(n_to), 32'd2);
        stub_en = 1'b1;

        // Reset in the middle of WAIT, late and stray DVs afterwards
        stub_lat = 5; req_a = 1'b1; bin_a = 6'd21;
        acks0 = n_ack_a + n_ack_b;
        to0 = n_to;
        wait_until(SEL_START, 5, "t5_start", n);
        step(); step();
        rst_n = 1'b0; req_a = 1'b0;
        #1;
        check("t5_rst_flags", 32'({conv_start, ack_a, ack_b, tmo, busy}), 32'd0);
        check("t5_rst_bin", 32'(conv_bin), 32'd0);
        check("t5_rst_bcd", 32'({bcd_a, bcd_b}), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        stray_dv = 1'b1;
        step();
        stray_dv = 1'b0;
        repeat (3) step();
        check("t5_no_ack", 32'(n_ack_a + n_ack_b), 32'(acks0));
        check("t5_no_to", 32'(n_to), 32'(to0));
        check("t5_bcd_a", 32'(bcd_a), 32'h00);
        check("t5_idle", 32'(busy), 32'd0);

        // Operand changes during START are ignored
        stub_lat = 2; req_a = 1'b1; bin_a = 6'd42;
        wait_until(SEL_START, 5, "t6_start", n);
        bin_a = 6'd10;
        step();
        check("t6_bin_hold", 32'(conv_bin), 32'd42);
        wait_until(SEL_ACK_A, 12, "t6_ack", n);
        check("t6_bin_end", 32'(conv_bin), 32'd42);
        check("t6_bcd_a", 32'(bcd_a), 32'h42);
        req_a = 1'b0;
        step();

        // DV on the terminal count wins; request dropped after grant still completes
        stub_lat = 8; req_b = 1'b1; bin_b = 6'd9;
        to0 = n_to;
        wait_until(SEL_START, 5, "t7_start", n);
        req_b = 1'b0;
        wait_until(SEL_ACK_B, 15, "t7_ack", n);
        check("t7_latency", 32'(n), 32'd9);
        check("t7_bcd_b", 32'(bcd_b), 32'h09);
        step();
        check("t7_no_to", 32'(n_to), 32'(to0));
        check("t7_idle", 32'(busy), 32'd0);

        check("excl_ack_to", 32'(n_excl), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
